// File: rtl/command_parser_rw.sv
// Word-stream command parser: decodes write/read frames, drives a simple
// register bus and returns an ACK word or the read value on the tx link.
module command_parser_rw #(
  parameter int unsigned WORD_WIDTH     = 8,
  parameter int unsigned ADDR_WORDS     = 1,
  parameter int unsigned VALUE_WORDS    = 4,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CMD_WRITE      = 'h01,
  parameter int unsigned CMD_READ       = 'h02,
  parameter int unsigned ACK_WORD       = 'h06
) (
  input  logic                                clk,
  input  logic                                i_reset_n,
  input  logic [WORD_WIDTH-1:0]               i_rx_data,
  input  logic                                i_rx_dv,
  output logic [WORD_WIDTH-1:0]               o_tx_data,
  output logic                                o_tx_dv,
  input  logic                                i_tx_busy,
  output logic [ADDR_WORDS*WORD_WIDTH-1:0]    o_w_addr,
  output logic [VALUE_WORDS*WORD_WIDTH-1:0]   o_w_data,
  output logic                                o_w_en,
  output logic [ADDR_WORDS*WORD_WIDTH-1:0]    o_r_addr,
  output logic                                o_r_en,
  input  logic [VALUE_WORDS*WORD_WIDTH-1:0]   i_r_data,
  output logic                                o_err,
  output logic                                o_busy
);

  localparam int unsigned W         = WORD_WIDTH;
  localparam int unsigned AW        = ADDR_WORDS * WORD_WIDTH;
  localparam int unsigned VW        = VALUE_WORDS * WORD_WIDTH;
  localparam int unsigned MAX_WORDS = (ADDR_WORDS > VALUE_WORDS) ? ADDR_WORDS : VALUE_WORDS;
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LAT_W     = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_VALUE, S_WRITE, S_READ_REQ, S_READ_WAIT, S_TX_LOAD, S_TX_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic            is_read_q, is_read_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [AW-1:0]   addr_sh_q, addr_sh_d;
  logic [VW-1:0]   data_sh_q, data_sh_d;
  logic [VW-1:0]   resp_q, resp_d;
  logic [W-1:0]    tx_data_q, tx_data_d;
  logic            tx_dv_q, tx_dv_d;
  logic [AW-1:0]   w_addr_q, w_addr_d;
  logic [VW-1:0]   w_data_q, w_data_d;
  logic            w_en_q, w_en_d;
  logic [AW-1:0]   r_addr_q, r_addr_d;
  logic            r_en_q, r_en_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   addr_nxt;
  logic [VW-1:0]   data_nxt;

  // State and output registers
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      is_read_q  <= 1'b0;
      word_cnt_q <= '0;
      timer_q    <= '0;
      lat_q      <= '0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      resp_q     <= '0;
      tx_data_q  <= '0;
      tx_dv_q    <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_en_q     <= 1'b0;
      r_addr_q   <= '0;
      r_en_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_read_q  <= is_read_d;
      word_cnt_q <= word_cnt_d;
      timer_q    <= timer_d;
      lat_q      <= lat_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      resp_q     <= resp_d;
      tx_data_q  <= tx_data_d;
      tx_dv_q    <= tx_dv_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_en_q     <= w_en_d;
      r_addr_q   <= r_addr_d;
      r_en_q     <= r_en_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    word_cnt_d = word_cnt_q;
    timer_d    = timer_q;
    lat_d      = lat_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    resp_d     = resp_q;
    tx_data_d  = tx_data_q;
    tx_dv_d    = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    w_en_d     = 1'b0;
    r_addr_d   = r_addr_q;
    r_en_d     = 1'b0;
    err_d      = 1'b0;
    addr_nxt   = (addr_sh_q << W) | AW'(i_rx_data);
    data_nxt   = (data_sh_q << W) | VW'(i_rx_data);

    // Words arriving while a command is being executed are dropped
    if (i_rx_dv && !(state_q inside {S_IDLE, S_ADDR, S_VALUE})) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_rx_dv) begin
          if (i_rx_data == W'(CMD_WRITE) || i_rx_data == W'(CMD_READ)) begin
            state_d    = S_ADDR;
            is_read_d  = (i_rx_data == W'(CMD_READ));
            word_cnt_d = '0;
            timer_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_ADDR: begin
        if (i_rx_dv) begin
          addr_sh_d = addr_nxt;
          timer_d   = '0;
          if (word_cnt_q == CNT_W'(ADDR_WORDS - 1)) begin
            word_cnt_d = '0;
            if (is_read_q) begin
              r_addr_d = addr_nxt;
              r_en_d   = 1'b1;
              state_d  = S_READ_REQ;
            end else begin
              state_d = S_VALUE;
            end
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_VALUE: begin
        if (i_rx_dv) begin
          data_sh_d = data_nxt;
          timer_d   = '0;
          if (word_cnt_q == CNT_W'(VALUE_WORDS - 1)) begin
            word_cnt_d = '0;
            w_addr_d   = addr_sh_q;
            w_data_d   = data_nxt;
            w_en_d     = 1'b1;
            state_d    = S_WRITE;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_WRITE: begin
        resp_d     = VW'(W'(ACK_WORD)) << (VW - W);
        word_cnt_d = CNT_W'(1);
        state_d    = S_TX_LOAD;
      end

      S_READ_REQ: begin
        lat_d   = '0;
        state_d = S_READ_WAIT;
      end

      S_READ_WAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
          resp_d     = i_r_data;
          word_cnt_d = CNT_W'(VALUE_WORDS);
          state_d    = S_TX_LOAD;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      S_TX_LOAD: begin
        if (!i_tx_busy) begin
          tx_data_d  = resp_q[VW-1 -: W];
          tx_dv_d    = 1'b1;
          resp_d     = resp_q << W;
          word_cnt_d = word_cnt_q - CNT_W'(1);
          state_d    = S_TX_WAIT;
        end
      end

      S_TX_WAIT: begin
        // tx_dv_q marks the first cycle, where the transmitter may not yet report busy
        if (!tx_dv_q && !i_tx_busy) begin
          state_d = (word_cnt_q == '0) ? S_IDLE : S_TX_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_tx_data = tx_data_q;
  assign o_tx_dv   = tx_dv_q;
  assign o_w_addr  = w_addr_q;
  assign o_w_data  = w_data_q;
  assign o_w_en    = w_en_q;
  assign o_r_addr  = r_addr_q;
  assign o_r_en    = r_en_q;
  assign o_err     = err_q;
  assign o_busy    = busy_q;

endmodule

// File: doc/command_parser_rw.md
COMMAND_PARSER_RW -- requirements
Module: command_parser_rw

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, meaning bits per received/transmitted byte-word.
REQ-002 SHALL have parameter ADDR_WORDS, default 1, meaning address words per command (MSW first).
REQ-003 SHALL have parameter VALUE_WORDS, default 4, meaning value words per write/read (MSW first).
REQ-004 SHALL have parameter READ_LATENCY, default 1, meaning clk cycles from o_r_en to valid i_r_data.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning max idle clk cycles between words of one command.
REQ-006 SHALL have parameters CMD_WRITE default 'h01, CMD_READ default 'h02, ACK_WORD default 'h06, meaning opcode and acknowledge values.
REQ-007 SHALL have ports: clk  in  1  system clock; i_reset_n  in  1  reset.
REQ-008 SHALL have one clock; reset is asynchronous and active-low.
REQ-009 SHALL have i_rx_data  in  WORD_WIDTH  received word; i_rx_dv  in  1  one-cycle strobe, word valid.
REQ-010 SHALL have o_tx_data  out  WORD_WIDTH  word to transmit; o_tx_dv  out  1  one-cycle transmit strobe; i_tx_busy  in  1  transmitter busy.
REQ-011 SHALL have o_w_addr  out  ADDR_WORDS*WORD_WIDTH; o_w_data  out  VALUE_WORDS*WORD_WIDTH; o_w_en  out  1  write strobe.
REQ-012 SHALL have o_r_addr  out  ADDR_WORDS*WORD_WIDTH; o_r_en  out  1  read strobe; i_r_data  in  VALUE_WORDS*WORD_WIDTH  read value.
REQ-013 SHALL have o_err  out  1  one-cycle error pulse; o_busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, ADDR, VALUE, WRITE, READ_REQ, READ_WAIT, TX_LOAD, TX_WAIT.
REQ-015 IDLE + i_rx_dv: CMD_WRITE or CMD_READ -> ADDR, opcode latched; other value -> stay IDLE, o_err pulse next cycle.
REQ-016 ADDR: each i_rx_dv shifts word into address register (MSW first); after ADDR_WORDS words -> VALUE (write) or READ_REQ (read).
REQ-017 VALUE: each i_rx_dv shifts word into data register; after VALUE_WORDS words -> WRITE.
REQ-018 WRITE: o_w_en high exactly one cycle with o_w_addr/o_w_data stable; next state TX_LOAD with ACK_WORD as sole response word.
REQ-019 READ_REQ: o_r_en high one cycle with o_r_addr valid -> READ_WAIT; after READ_LATENCY cycles i_r_data captured into response register -> TX_LOAD.
REQ-020 TX_LOAD: waits for i_tx_busy low, then pulses o_tx_dv one cycle with current response word (MSW first) -> TX_WAIT.
REQ-021 TX_WAIT: ignores i_tx_busy for the first cycle, then waits for i_tx_busy low; more words remain -> TX_LOAD, else -> IDLE.
REQ-022 Read response SHALL be VALUE_WORDS words; write response SHALL be 1 word (ACK_WORD).
REQ-023 Timeout counter SHALL clear on every i_rx_dv and on entry to ADDR; reaching TIMEOUT_CYCLES in ADDR or VALUE -> IDLE, o_err pulse, no o_w_en/o_r_en.
REQ-024 i_rx_dv in WRITE, READ_REQ, READ_WAIT, TX_LOAD, TX_WAIT SHALL drop the word and pulse o_err; state unaffected.
REQ-025 Word counters SHALL be sized $clog2(max(ADDR_WORDS,VALUE_WORDS)+1); no wrap within a command.
REQ-026 o_w_addr/o_w_data/o_r_addr SHALL hold last latched values between commands.
REQ-027 Simultaneous timeout expiry and i_rx_dv in the same cycle: the word SHALL be accepted; no timeout.

Reset
REQ-028 i_reset_n low SHALL immediately force IDLE and clear all counters and registers.
REQ-029 Reset values: o_tx_data 0, o_tx_dv 0, o_w_addr 0, o_w_data 0, o_w_en 0, o_r_addr 0, o_r_en 0, o_err 0, o_busy 0.
REQ-030 Reset mid-command SHALL discard the partial command; no strobe SHALL be issued after release.

Verification
REQ-031 Write: rx 01,12,34,56,78,9A -> one o_w_en, o_w_addr 'h12, o_w_data 'h3456789A; tx emits 06.
REQ-032 Read-back: after REQ-031 write, rx 02,12 -> one o_r_en, o_r_addr 'h12; tx emits 34,56,78,9A in order, each o_tx_dv only with i_tx_busy low.
REQ-033 Bad opcode: rx 7F -> o_err one pulse, o_busy stays 0, no strobes.
REQ-034 Timeout (TIMEOUT_CYCLES=50): rx 01,12,34 then silence 60 cycles -> o_err at cycle 50, IDLE; subsequent full write to 'h05 completes correctly.
REQ-035 Sweep: write 'hBBB00B00+addr to all 256 addresses then read each -> every read matches; rx during response -> o_err, response intact.
REQ-036 Reset asserted after rx 01,12,34 -> outputs at reset values; after release no o_w_en until a new complete command.
